// File: rtl/juggler_pkg.sv
// Shared types and constants for the juggler video path: screen coordinate
// widths, the RGB444 colour type, per-ball colours and the renderer FSM states.
package juggler_pkg;

    localparam int unsigned MAX_BALLS = 7;
    localparam int unsigned X_W       = 11;
    localparam int unsigned Y_W       = 10;
    localparam int unsigned IDX_W     = 3;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t BALL_COLORS [MAX_BALLS] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hFFF
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE
    } state_t;

endpackage

// File: rtl/render_balls_if.sv
// Trajectory, pixel-coordinate and rendered-pixel signals of the ball renderer.
// The master drives positions and pixel coordinates; the slave (renderer) returns colours.
interface render_balls_if
    import juggler_pkg::*;
();
    logic                          nf_in;
    logic [MAX_BALLS-1:0][X_W-1:0] traj_x_in;
    logic [MAX_BALLS-1:0][Y_W-1:0] traj_y_in;
    logic                          traj_valid_in;
    logic [IDX_W-1:0]              num_balls_in;
    logic [X_W-1:0]                hcount_in;
    logic [Y_W-1:0]                vcount_in;
    logic                          data_valid_in;
    rgb444_t                       pixel_out;
    logic                          ball_hit_out;
    logic [IDX_W-1:0]              ball_idx_out;
    logic                          data_valid_out;

    modport master (
        output nf_in, traj_x_in, traj_y_in, traj_valid_in, num_balls_in,
        output hcount_in, vcount_in, data_valid_in,
        input  pixel_out, ball_hit_out, ball_idx_out, data_valid_out
    );

    modport slave (
        input  nf_in, traj_x_in, traj_y_in, traj_valid_in, num_balls_in,
        input  hcount_in, vcount_in, data_valid_in,
        output pixel_out, ball_hit_out, ball_idx_out, data_valid_out
    );

endinterface

// File: rtl/ball_hit_test.sv
// Per-ball distance test: stage 1 registers signed dx/dy, stage 2 registers
// whether the squared distance is inside the radius for a live ball.
module ball_hit_test
    import juggler_pkg::*;
#(
    parameter int unsigned RADIUS = 8
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [X_W-1:0] hcount_in,
    input  logic [Y_W-1:0] vcount_in,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic           live_in,
    output logic           hit_out
);
    localparam logic [22:0] R2 = 23'(RADIUS * RADIUS);

    logic signed [X_W:0] dx_q;
    logic signed [Y_W:0] dy_q;
    logic                live_q;
    logic signed [22:0]  dx_e;
    logic signed [22:0]  dy_e;
    logic [22:0]         d2;

    // Sign-extend before squaring so negative offsets near the screen edge square correctly.
    always_comb begin
        dx_e = 23'(dx_q);
        dy_e = 23'(dy_q);
        d2   = dx_e * dx_e + dy_e * dy_e;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dx_q    <= '0;
            dy_q    <= '0;
            live_q  <= 1'b0;
            hit_out <= 1'b0;
        end else begin
            dx_q    <= $signed({1'b0, hcount_in} - {1'b0, x_in});
            dy_q    <= $signed({1'b0, vcount_in} - {1'b0, y_in});
            live_q  <= live_in;
            hit_out <= live_q && (d2 <= R2);
        end
    end

endmodule

// File: rtl/render_balls.sv
// Ball renderer: double-buffered ball positions swapped on the frame strobe,
// and a 3-stage per-pixel pipeline colouring the lowest-index ball hit.
module render_balls
    import juggler_pkg::*;
#(
    parameter int unsigned RADIUS   = 8,
    parameter rgb444_t     BG_COLOR = 12'h000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    render_balls_if.slave bus
);
    state_t                        state_q, state_d;
    logic [MAX_BALLS-1:0][X_W-1:0] shadow_x, active_x;
    logic [MAX_BALLS-1:0][Y_W-1:0] shadow_y, active_y;
    logic [IDX_W-1:0]              shadow_n, active_n;
    logic [MAX_BALLS-1:0]          live;
    logic [MAX_BALLS-1:0]          hit_s2;
    logic                          dv_s1, dv_s2;
    logic                          any_hit;
    rgb444_t                       win_col;
    logic [IDX_W-1:0]              win_idx;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.traj_valid_in) state_d = WAIT_FRAME;
            WAIT_FRAME: if (bus.nf_in)         state_d = ACTIVE;
            ACTIVE:                            state_d = ACTIVE;
            default:                           state_d = IDLE;
        endcase
    end

    // Active bank reads the pre-edge shadow, so a same-cycle capture lands only in the shadow.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shadow_x <= '0;
            shadow_y <= '0;
            shadow_n <= '0;
            active_x <= '0;
            active_y <= '0;
            active_n <= '0;
        end else begin
            if (bus.traj_valid_in) begin
                shadow_x <= bus.traj_x_in;
                shadow_y <= bus.traj_y_in;
                shadow_n <= bus.num_balls_in;
            end
            if (bus.nf_in && state_q != IDLE) begin
                active_x <= shadow_x;
                active_y <= shadow_y;
                active_n <= shadow_n;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dv_s1 <= 1'b0;
            dv_s2 <= 1'b0;
        end else begin
            dv_s1 <= bus.data_valid_in;
            dv_s2 <= dv_s1;
        end
    end

    // Priority chain runs through per-ball scopes so each link is its own signal.
    for (genvar g = 0; g < MAX_BALLS; g++) begin : g_ball
        logic             seen_in, seen_o;
        rgb444_t          col_in, col_o;
        logic [IDX_W-1:0] idx_in, idx_o;

        assign live[g] = (state_q == ACTIVE) && (IDX_W'(g) < active_n) && (active_y[g] != '0);

        ball_hit_test #(.RADIUS(RADIUS)) u_hit (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .hcount_in (bus.hcount_in),
            .vcount_in (bus.vcount_in),
            .x_in      (active_x[g]),
            .y_in      (active_y[g]),
            .live_in   (live[g]),
            .hit_out   (hit_s2[g])
        );

        if (g == 0) begin : g_first
            assign seen_in = 1'b0;
            assign col_in  = BG_COLOR;
            assign idx_in  = '0;
        end else begin : g_next
            assign seen_in = g_ball[g-1].seen_o;
            assign col_in  = g_ball[g-1].col_o;
            assign idx_in  = g_ball[g-1].idx_o;
        end

        assign seen_o = seen_in | hit_s2[g];
        assign col_o  = (hit_s2[g] && !seen_in) ? BALL_COLORS[g] : col_in;
        assign idx_o  = (hit_s2[g] && !seen_in) ? IDX_W'(g) : idx_in;
    end

    assign any_hit = g_ball[MAX_BALLS-1].seen_o;
    assign win_col = g_ball[MAX_BALLS-1].col_o;
    assign win_idx = g_ball[MAX_BALLS-1].idx_o;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bus.pixel_out      <= BG_COLOR;
            bus.ball_hit_out   <= 1'b0;
            bus.ball_idx_out   <= '0;
            bus.data_valid_out <= 1'b0;
        end else begin
            bus.data_valid_out <= dv_s2;
            bus.ball_hit_out   <= dv_s2 && any_hit;
            bus.ball_idx_out   <= (dv_s2 && any_hit) ? win_idx : '0;
            bus.pixel_out      <= (dv_s2 && any_hit) ? win_col : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_render_balls.sv
// Self-checking bench for render_balls: directed scenarios plus randomized
// traffic compared against a behavioural frame/bank/distance model.
module tb_render_balls;
    import juggler_pkg::*;

    localparam int unsigned RADIUS = 8;
    localparam rgb444_t     BG     = 12'h000;

    logic clk_in = 1'b0;
    logic rst_in;

    render_balls_if bus();

    render_balls #(.RADIUS(RADIUS), .BG_COLOR(BG)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Model: 0 = waiting for positions, 1 = waiting for frame, 2 = rendering.
    int m_state;
    int sh_x [MAX_BALLS];
    int sh_y [MAX_BALLS];
    int sh_n;
    int ac_x [MAX_BALLS];
    int ac_y [MAX_BALLS];
    int ac_n;
    logic [16:0] e_pipe [3];   // {data_valid, hit, idx[2:0], pixel[11:0]}

    function automatic logic [16:0] hitv(input int idx);
        return {2'b11, 3'(idx), BALL_COLORS[idx]};
    endfunction

    function automatic logic [16:0] missv();
        return {2'b10, 3'b000, BG};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.data_valid_out, bus.ball_hit_out, bus.ball_idx_out, bus.pixel_out};
    endfunction

    function automatic logic [16:0] ref_out(input int h, input int v, input bit dv);
        int dx, dy;
        if (!dv) return {5'b00000, BG};
        if (m_state == 2) begin
            for (int i = 0; i < MAX_BALLS; i++) begin
                if (i < ac_n && ac_y[i] != 0) begin
                    dx = h - ac_x[i];
                    dy = v - ac_y[i];
                    if (dx * dx + dy * dy <= int'(RADIUS * RADIUS)) return hitv(i);
                end
            end
        end
        return missv();
    endfunction

    task automatic model_reset();
        m_state = 0;
        sh_n = 0;
        ac_n = 0;
        for (int i = 0; i < MAX_BALLS; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
        end
        for (int i = 0; i < 3; i++) e_pipe[i] = {5'b00000, BG};
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic cycle();
        logic [16:0] e;
        e = ref_out(int'(bus.hcount_in), int'(bus.vcount_in), bus.data_valid_in);
        e_pipe[2] = e_pipe[1];
        e_pipe[1] = e_pipe[0];
        e_pipe[0] = e;
        if (bus.nf_in && m_state != 0) begin
            for (int i = 0; i < MAX_BALLS; i++) begin
                ac_x[i] = sh_x[i];
                ac_y[i] = sh_y[i];
            end
            ac_n = sh_n;
        end
        if (bus.traj_valid_in) begin
            for (int i = 0; i < MAX_BALLS; i++) begin
                sh_x[i] = int'(bus.traj_x_in[3'(i)]);
                sh_y[i] = int'(bus.traj_y_in[3'(i)]);
            end
            sh_n = int'(bus.num_balls_in);
        end
        if (m_state == 0 && bus.traj_valid_in) m_state = 1;
        else if (m_state == 1 && bus.nf_in)    m_state = 2;
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_ball(input int i, input int x, input int y);
        bus.traj_x_in[3'(i)] = 11'(x);
        bus.traj_y_in[3'(i)] = 10'(y);
    endtask

    task automatic pulse_traj(input int n);
        bus.num_balls_in  = 3'(n);
        bus.traj_valid_in = 1'b1;
        cycle();
        bus.traj_valid_in = 1'b0;
    endtask

    task automatic pulse_nf();
        bus.nf_in = 1'b1;
        cycle();
        bus.nf_in = 1'b0;
    endtask

    // Streams pixels back to back and collects observed/model outputs per pixel.
    task automatic run_pixels(input int hs[$], input int vs[$],
                              output logic [16:0] got[$], output logic [16:0] exp[$]);
        got = {};
        exp = {};
        for (int k = 0; k < hs.size() + 2; k++) begin
            if (k < hs.size()) begin
                bus.hcount_in     = 11'(hs[k]);
                bus.vcount_in     = 10'(vs[k]);
                bus.data_valid_in = 1'b1;
            end else begin
                bus.data_valid_in = 1'b0;
            end
            cycle();
            if (k >= 2) begin
                got.push_back(obs());
                exp.push_back(e_pipe[2]);
            end
        end
        bus.data_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        rst_in = 1'b0;
        model_reset();
        #12;
        checks++; if (bus.pixel_out !== 12'h000) begin errors++; $display("FAIL reset_pixel: got=%h exp=000", bus.pixel_out); end
        checks++; if (bus.data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_dv: got=%b exp=0", bus.data_valid_out); end
        checks++; if (bus.ball_hit_out !== 1'b0) begin errors++; $display("FAIL reset_hit: got=%b exp=0", bus.ball_hit_out); end
        checks++; if (bus.ball_idx_out !== 3'd0) begin errors++; $display("FAIL reset_idx: got=%0d exp=0", bus.ball_idx_out); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got=%0d exp=%0d", dut.state_q, IDLE); end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        hs = {0, 5, 100};
        vs = {0, 5, 200};
        run_pixels(hs, vs, got, exp);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== missv()) begin errors++; $display("FAIL idle_nohit[%0d]: got=%h exp=%h", i, got[i], missv()); end
        end
    endtask

    task automatic test_basic();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        set_ball(0, 100, 200);
        pulse_traj(1);
        pulse_nf();
        hs = {104, 109, 100, 108, 100};
        vs = {203, 200, 200, 200, 209};
        run_pixels(hs, vs, got, exp);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL basic[%0d]: got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (got[0] !== hitv(0)) begin errors++; $display("FAIL basic_hit: got=%h exp=%h", got[0], hitv(0)); end
        checks++; if (got[1] !== missv()) begin errors++; $display("FAIL basic_miss: got=%h exp=%h", got[1], missv()); end
        checks++; if (got[3] !== hitv(0)) begin errors++; $display("FAIL basic_radius: got=%h exp=%h", got[3], hitv(0)); end
    endtask

    task automatic test_priority();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        set_ball(0, 50, 50);
        set_ball(1, 400, 400);
        set_ball(2, 50, 50);
        pulse_traj(3);
        pulse_nf();
        hs = {50, 58, 400};
        vs = {50, 50, 400};
        run_pixels(hs, vs, got, exp);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL priority[%0d]: got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (got[0] !== hitv(0)) begin errors++; $display("FAIL priority_low: got=%h exp=%h", got[0], hitv(0)); end
        checks++; if (got[2] !== hitv(1)) begin errors++; $display("FAIL priority_b1: got=%h exp=%h", got[2], hitv(1)); end
    endtask

    task automatic test_liveness();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        set_ball(0, 600, 400);
        set_ball(1, 400, 0);
        set_ball(2, 200, 100);
        set_ball(3, 300, 300);
        pulse_traj(3);
        pulse_nf();
        hs = {300, 400, 400, 200};
        vs = {300, 3, 0, 100};
        run_pixels(hs, vs, got, exp);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL live[%0d]: got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (got[0] !== missv()) begin errors++; $display("FAIL live_num: got=%h exp=%h", got[0], missv()); end
        checks++; if (got[1] !== missv()) begin errors++; $display("FAIL live_y0: got=%h exp=%h", got[1], missv()); end
        checks++; if (got[3] !== hitv(2)) begin errors++; $display("FAIL live_b2: got=%h exp=%h", got[3], hitv(2)); end
    endtask

    task automatic test_no_tearing();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        set_ball(0, 100, 100);
        pulse_traj(1);
        pulse_nf();
        set_ball(0, 500, 100);
        pulse_traj(1);
        hs = {100, 500};
        vs = {100, 100};
        run_pixels(hs, vs, got, exp);
        checks++; if (got[0] !== hitv(0)) begin errors++; $display("FAIL tear_old_hit: got=%h exp=%h", got[0], hitv(0)); end
        checks++; if (got[1] !== missv()) begin errors++; $display("FAIL tear_new_miss: got=%h exp=%h", got[1], missv()); end
        pulse_nf();
        run_pixels(hs, vs, got, exp);
        checks++; if (got[0] !== missv()) begin errors++; $display("FAIL tear_old_miss: got=%h exp=%h", got[0], missv()); end
        checks++; if (got[1] !== hitv(0)) begin errors++; $display("FAIL tear_new_hit: got=%h exp=%h", got[1], hitv(0)); end
    endtask

    task automatic test_edge();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        set_ball(0, 3, 5);
        pulse_traj(1);
        pulse_nf();
        hs = {0, 3, 0};
        vs = {0, 13, 13};
        run_pixels(hs, vs, got, exp);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL edge_a[%0d]: got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (got[0] !== hitv(0)) begin errors++; $display("FAIL edge_origin_hit: got=%h exp=%h", got[0], hitv(0)); end
        set_ball(0, 10, 5);
        pulse_traj(1);
        pulse_nf();
        hs = {0, 2};
        vs = {0, 5};
        run_pixels(hs, vs, got, exp);
        checks++; if (got[0] !== missv()) begin errors++; $display("FAIL edge_origin_miss: got=%h exp=%h", got[0], missv()); end
        checks++; if (got[1] !== hitv(0)) begin errors++; $display("FAIL edge_left_hit: got=%h exp=%h", got[1], hitv(0)); end
        set_ball(0, 0, 1);
        pulse_traj(1);
        pulse_nf();
        hs = {2047, 0, 5, 0};
        vs = {1, 1023, 1, 0};
        run_pixels(hs, vs, got, exp);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL edge_c[%0d]: got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (got[0] !== missv()) begin errors++; $display("FAIL edge_xwrap: got=%h exp=%h", got[0], missv()); end
        checks++; if (got[1] !== missv()) begin errors++; $display("FAIL edge_ywrap: got=%h exp=%h", got[1], missv()); end
    endtask

    task automatic test_random();
        int j, h, v;
        for (int c = 0; c < 3000; c++) begin
            bus.traj_valid_in = ($urandom_range(7) == 0);
            if (bus.traj_valid_in) begin
                for (int i = 0; i < MAX_BALLS; i++)
                    set_ball(i, int'($urandom_range(700)),
                             ($urandom_range(7) == 0) ? 0 : int'($urandom_range(500, 1)));
                bus.num_balls_in = 3'($urandom_range(7));
            end
            bus.nf_in         = ($urandom_range(15) == 0);
            bus.data_valid_in = ($urandom_range(3) != 0);
            j = int'($urandom_range(MAX_BALLS - 1));
            if ($urandom_range(7) == 0) begin
                h = int'($urandom_range(2047));
                v = int'($urandom_range(1023));
            end else begin
                h = ac_x[j] + int'($urandom_range(24)) - 12;
                v = ac_y[j] + int'($urandom_range(24)) - 12;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
            end
            bus.hcount_in = 11'(h);
            bus.vcount_in = 10'(v);
            cycle();
            checks++;
            if (obs() !== e_pipe[2]) begin
                errors++;
                $display("FAIL random[%0d]: got=%h exp=%h", c, obs(), e_pipe[2]);
            end
        end
        bus.traj_valid_in = 1'b0;
        bus.nf_in         = 1'b0;
        bus.data_valid_in = 1'b0;
    endtask

    task automatic test_midframe_reset();
        int hs[$], vs[$];
        logic [16:0] got[$], exp[$];
        set_ball(0, 100, 100);
        pulse_traj(1);
        pulse_nf();
        bus.hcount_in     = 11'd100;
        bus.vcount_in     = 10'd100;
        bus.data_valid_in = 1'b1;
        cycle();
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        checks++; if (obs() !== {5'b00000, BG}) begin errors++; $display("FAIL async_reset_out: got=%h exp=%h", obs(), {5'b00000, BG}); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL async_reset_state: got=%0d exp=%0d", dut.state_q, IDLE); end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        bus.data_valid_in = 1'b0;
        bus.nf_in = 1'b1;
        hs = {100, 100};
        vs = {100, 100};
        run_pixels(hs, vs, got, exp);
        bus.nf_in = 1'b0;
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== missv()) begin errors++; $display("FAIL post_reset_nohit[%0d]: got=%h exp=%h", i, got[i], missv()); end
        end
        pulse_traj(1);
        pulse_nf();
        run_pixels(hs, vs, got, exp);
        checks++; if (got[0] !== hitv(0)) begin errors++; $display("FAIL post_reset_hit: got=%h exp=%h", got[0], hitv(0)); end
    endtask

    initial begin
        bus.nf_in         = 1'b0;
        bus.traj_x_in     = '0;
        bus.traj_y_in     = '0;
        bus.traj_valid_in = 1'b0;
        bus.num_balls_in  = '0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;
        bus.data_valid_in = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_liveness();
        test_no_tearing();
        test_edge();
        test_random();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
